prog_loader: RTL

- Synthesizable boot/program loader for the pipelined CPU wrapper family.
- Receives a framed word stream over a valid/ready handshake and writes the payload into instruction memory at an incrementing address.
- Holds the CPU in reset for the whole load and releases it a fixed number of cycles after a good frame; it also presents the frame start address as the boot vector.
- Replaces hierarchical memory preloading, so silicon and benches use the same load path.

---
 rtl/prog_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: loads a framed valid/ready word stream into instruction memory and sequences CPU reset.
// Define PROG_LOADER_CSUM_EN to require a trailing checksum beat per frame.
module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] SYNC = 8'hA5,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rstn,
    output logic [ADDR_W-1:0] boot_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int AB = (ADDR_W + DATA_W - 1) / DATA_W;
    localparam int FW = AB * DATA_W;
    localparam int CW = $clog2(RST_HOLD + 1);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, TAIL, HOLD, RUN, ERR} state_t;
`ifdef PROG_LOADER_CSUM_EN
    localparam state_t AFTER = TAIL;
`else
    localparam state_t AFTER = HOLD;
`endif
    state_t state, nxt;
    logic [FW-1:0] field, field_nxt;
    logic [7:0] bcnt;
    logic [ADDR_W-1:0] start, ptr, left;
    logic [CW-1:0] hcnt;
    logic accept, is_sync, field_last, tail_good;
    assign accept = s_valid & s_ready;
    assign is_sync = s_data == SYNC;
    assign field_last = bcnt == 8'(AB - 1);
    // Header fields arrive little-endian: shift each beat in from the top.
    assign field_nxt = (field >> DATA_W) | (FW'(s_data) << (FW - DATA_W));
    always_comb begin
        nxt = state;
        case (state)
            IDLE, RUN, ERR: if (accept && is_sync) nxt = ADDR;
            ADDR: if (accept && field_last) nxt = LEN;
            LEN: if (accept && field_last) nxt = field_nxt[ADDR_W-1:0] == '0 ? AFTER : DATA;
            DATA: if (accept && left == ADDR_W'(1)) nxt = AFTER;
            TAIL: if (accept) nxt = tail_good ? HOLD : ERR;
            HOLD: if (hcnt == CW'(RST_HOLD - 1)) nxt = RUN;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            s_ready <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_rstn <= 1'b0;
            boot_addr <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            field <= '0;
            bcnt <= '0;
            start <= '0;
            ptr <= '0;
            left <= '0;
            hcnt <= '0;
        end else begin
            state <= nxt;
            s_ready <= 1'b1;
            cpu_rstn <= nxt == RUN;
            done <= nxt == RUN;
            busy <= nxt inside {ADDR, LEN, DATA, TAIL, HOLD};
            mem_we <= accept && state == DATA;
            hcnt <= state == HOLD ? hcnt + 1'b1 : '0;
            if (accept && state == DATA) begin
                mem_addr <= ptr;
                mem_wdata <= s_data;
                ptr <= ptr + 1'b1;
                left <= left - 1'b1;
            end
            if (accept && (state == ADDR || state == LEN)) begin
                field <= field_nxt;
                bcnt <= field_last ? '0 : bcnt + 1'b1;
            end
            if (accept && state == ADDR && field_last) start <= field_nxt[ADDR_W-1:0];
            if (accept && state == LEN && field_last) begin
                ptr <= start;
                left <= field_nxt[ADDR_W-1:0];
            end
            if (nxt == HOLD && state != HOLD) boot_addr <= start;
        end
    end
`ifdef PROG_LOADER_CSUM_EN
    logic [DATA_W-1:0] sum, chk;
    assign chk = sum + s_data;
    assign tail_good = chk == '0;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            err <= nxt == ERR;
            if (accept && is_sync && state inside {IDLE, RUN, ERR}) sum <= '0;
            else if (accept && state inside {ADDR, LEN, DATA}) sum <= chk;
        end
    end
`else
    assign tail_good = 1'b1;
    assign err = 1'b0;
`endif
endmodule
